// File: rtl/sprite_plotter_pkg.sv
// Shared definitions for the sprite plotter and its neighbours.
//   - state_t : plotter FSM encoding (IDLE, ERASE, DRAW, DONE)
//   - SCR_X_MAX / SCR_Y_MAX : largest on-screen coordinates. The VGA
//     adapter wrapper uses them as well.
//   - X_W / Y_W / COLOUR_W : coordinate and colour widths on the adapter port
//   - OFS_W : width of the sprite offset counters (sprites up to 16x16)
package sprite_plotter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SCR_X_MAX = 159;
  localparam int SCR_Y_MAX = 119;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int COLOUR_W  = 3;
  localparam int OFS_W     = 4;

endpackage

// File: rtl/sprite_plotter_if.sv
// Bundle for the sprite plotter request/pixel port.
//   Request side : start, x_in, y_in, colour_in, bg_colour
//   Pixel side   : x_out, y_out, colour_out, plot, busy, done
// The handshake is start/busy/done. A start is taken only while the plotter
// is idle, not in the cycle that done is high. busy covers the whole pass.
// done pulses for one cycle at the end of the pass. plot qualifies
// x_out/y_out/colour_out, and the adapter writes exactly one pixel per cycle.
// Modports:
//   master : game-logic side (drives the request, observes the pixels)
//   slave  : the plotter
interface sprite_plotter_if;
  import sprite_plotter_pkg::*;

  logic                start;
  logic [X_W-1:0]      x_in;
  logic [Y_W-1:0]      y_in;
  logic [COLOUR_W-1:0] colour_in;
  logic [COLOUR_W-1:0] bg_colour;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output start, x_in, y_in, colour_in, bg_colour,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    input  start, x_in, y_in, colour_in, bg_colour,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/sprite_plotter_offset_scan.sv
// Row-major (col, row) offset counter that scans a sprite's pixels.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   clear_i     : forces both counters to 0 (this has priority over en_i)
//   en_i        : advance one pixel
//   col_o/row_o : current offset
//   last_o      : current offset is the final pixel (W-1, H-1)
// After the last pixel the counter wraps to (0, 0). Back-to-back phases
// therefore need no extra clear cycle.
module sprite_offset_scan
  import sprite_plotter_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [OFS_W-1:0] col_o,
  output logic [OFS_W-1:0] row_o,
  output logic             last_o
);

  localparam logic [OFS_W-1:0] COL_LAST = OFS_W'(SPRITE_W - 1);
  localparam logic [OFS_W-1:0] ROW_LAST = OFS_W'(SPRITE_H - 1);

  logic [OFS_W-1:0] col_q, col_d;
  logic [OFS_W-1:0] row_q, row_d;
  logic             col_last;

  assign col_last = (col_q == COL_LAST);
  assign last_o   = col_last && (row_q == ROW_LAST);
  assign col_o    = col_q;
  assign row_o    = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (en_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = last_o ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: turns one (x, y) position request into per-pixel writes
// for the VGA frame-buffer adapter. The block first erases the sprite at its
// previous position with the background colour. It then draws the sprite at
// the new position.
// Ports:
//   clk, resetn : clock and synchronous active-low reset
//   bus         : sprite_plotter_if.slave. It carries the request
//                 (start, x_in, y_in, colour_in, bg_colour) and the pixel
//                 stream (x_out, y_out, colour_out, plot, busy, done).
//   state_o     : current FSM state, for debug and observation
// All bus outputs are registered. Each register is loaded from the state
// held before the edge, so a phase entered at edge E emits its first pixel
// in the cycle after edge E+1.
module sprite_plotter
  import sprite_plotter_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4,
  parameter int X_MAX    = SCR_X_MAX,
  parameter int Y_MAX    = SCR_Y_MAX
) (
  input  logic             clk,
  input  logic             resetn,
  sprite_plotter_if.slave  bus,
  output state_t           state_o
);

  // The sums are one bit wider than the outputs. This keeps wrap-around
  // from hiding an off-screen pixel.
  localparam logic [X_W:0] X_LIM = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(Y_MAX);

  state_t              state_q;
  logic [X_W-1:0]      x_lat_q, prev_x_q, x_out_q;
  logic [Y_W-1:0]      y_lat_q, prev_y_q, y_out_q;
  logic [COLOUR_W-1:0] colour_lat_q, bg_lat_q, colour_out_q;
  logic                prev_valid_q, plot_q, busy_q, done_q;

  logic [OFS_W-1:0]    col, row;
  logic                scan_last, scan_en;

  logic [X_W-1:0]      base_x_d;
  logic [Y_W-1:0]      base_y_d;
  logic [X_W:0]        px_x_d;
  logic [Y_W:0]        px_y_d;
  logic                px_vis_d;

  assign scan_en = (state_q == ST_ERASE) || (state_q == ST_DRAW);

  sprite_offset_scan #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (!scan_en),
    .en_i    (scan_en),
    .col_o   (col),
    .row_o   (row),
    .last_o  (scan_last)
  );

  // The erase phase works from the previously drawn position. The draw
  // phase works from the position latched at start.
  always_comb begin
    base_x_d = x_lat_q;
    base_y_d = y_lat_q;
    if (state_q == ST_ERASE) begin
      base_x_d = prev_x_q;
      base_y_d = prev_y_q;
    end
    px_x_d   = {1'b0, base_x_d} + {{(X_W + 1 - OFS_W){1'b0}}, col};
    px_y_d   = {1'b0, base_y_d} + {{(Y_W + 1 - OFS_W){1'b0}}, row};
    px_vis_d = (px_x_d <= X_LIM) && (px_y_d <= Y_LIM);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      colour_lat_q <= '0;
      bg_lat_q     <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_valid_q <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      busy_q <= (state_q != ST_IDLE);
      plot_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Ignore a start while done is still showing. The requester sees
          // done and the restart slot in separate cycles.
          if (bus.start && !done_q) begin
            x_lat_q      <= bus.x_in;
            y_lat_q      <= bus.y_in;
            colour_lat_q <= bus.colour_in;
            bg_lat_q     <= bus.bg_colour;
            state_q      <= prev_valid_q ? ST_ERASE : ST_DRAW;
          end
        end
        ST_ERASE, ST_DRAW: begin
          // Off-screen pixels still use their cycle. This keeps pass
          // timing independent of position.
          x_out_q      <= px_x_d[X_W-1:0];
          y_out_q      <= px_y_d[Y_W-1:0];
          colour_out_q <= (state_q == ST_ERASE) ? bg_lat_q : colour_lat_q;
          plot_q       <= px_vis_d;
          if (scan_last) begin
            state_q <= (state_q == ST_ERASE) ? ST_DRAW : ST_DONE;
          end
        end
        ST_DONE: begin
          done_q       <= 1'b1;
          prev_x_q     <= x_lat_q;
          prev_y_q     <= y_lat_q;
          prev_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.colour_out = colour_out_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign state_o        = state_q;

endmodule
